mem_port_arbiter: RTL and testbench

//   Shares the PORTS read and PORTS write ports of one memDP instance between NREQ requesters.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memDP-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PORTS = 2,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NREQ-1:0]             rd_req_valid;
  logic [NREQ-1:0][AW-1:0]     rd_req_addr;
  logic [NREQ-1:0]             rd_req_ready;
  logic [NREQ-1:0]             rd_rsp_valid;
  logic [NREQ-1:0][WIDTH-1:0]  rd_rsp_data;

  logic [NREQ-1:0]             wr_req_valid;
  logic [NREQ-1:0][AW-1:0]     wr_req_addr;
  logic [NREQ-1:0][WIDTH-1:0]  wr_req_data;
  logic [NREQ-1:0]             wr_req_ready;

  logic [PORTS-1:0]            mem_re;
  logic [PORTS-1:0][AW-1:0]    mem_raddr;
  logic [PORTS-1:0][WIDTH-1:0] mem_rdata;
  logic [PORTS-1:0]            mem_we;
  logic [PORTS-1:0][AW-1:0]    mem_waddr;
  logic [PORTS-1:0][WIDTH-1:0] mem_wdata;

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_req_ready,
    output mem_re, mem_raddr,
    input  mem_rdata,
    output mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_req_ready,
    input  mem_re, mem_raddr,
    output mem_rdata,
    input  mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing PORTS read and PORTS write ports of a non-bypass memDP
// among NREQ requesters; read data comes back registered one cycle after the grant.
module mem_port_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PORTS = 2,
  parameter int unsigned NREQ  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus_io
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [PW-1:0] idx_t;

  idx_t                       rd_ptr_q, rd_ptr_d;
  idx_t                       wr_ptr_q, wr_ptr_d;
  logic [NREQ-1:0]            rd_rsp_valid_q, rd_rsp_valid_d;
  logic [NREQ-1:0][WIDTH-1:0] rd_rsp_data_q, rd_rsp_data_d;

  logic [NREQ-1:0]             rd_grant;
  logic [NREQ-1:0]             wr_grant;
  logic [PORTS-1:0]            re;
  logic [PORTS-1:0]            we;
  logic [PORTS-1:0][AW-1:0]    raddr;
  logic [PORTS-1:0][AW-1:0]    waddr;
  logic [PORTS-1:0][WIDTH-1:0] wdata;
  idx_t [PORTS-1:0]            rd_sel;

  function automatic idx_t wrap_inc(idx_t v);
    if (v == idx_t'(NREQ - 1)) begin
      return '0;
    end
    return v + idx_t'(1);
  endfunction

  // Read scan: first PORTS valid requesters from rd_ptr_q, packed onto ports in scan order.
  always_comb begin
    int unsigned n;
    idx_t        idx;
    idx_t        last;
    rd_grant = '0;
    re       = '0;
    raddr    = '0;
    rd_sel   = '0;
    n        = 0;
    idx      = rd_ptr_q;
    last     = rd_ptr_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!rst_i && bus_io.rd_req_valid[idx] && (n < PORTS)) begin
        rd_grant[idx] = 1'b1;
        re[n]         = 1'b1;
        raddr[n]      = bus_io.rd_req_addr[idx];
        rd_sel[n]     = idx;
        last          = idx;
        n++;
      end
      idx = wrap_inc(idx);
    end
    rd_ptr_d = (n != 0) ? wrap_inc(last) : rd_ptr_q;
  end

  // Write scan: as for reads, but a candidate colliding with an already-granted address
  // this cycle is passed over so no two write ports target the same entry.
  always_comb begin
    int unsigned n;
    idx_t        idx;
    idx_t        last;
    logic        clash;
    wr_grant = '0;
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    n        = 0;
    idx      = wr_ptr_q;
    last     = wr_ptr_q;
    clash    = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      clash = 1'b0;
      for (int p = 0; p < int'(PORTS); p++) begin
        if (we[p] && (waddr[p] == bus_io.wr_req_addr[idx])) begin
          clash = 1'b1;
        end
      end
      if (!rst_i && bus_io.wr_req_valid[idx] && !clash && (n < PORTS)) begin
        wr_grant[idx] = 1'b1;
        we[n]         = 1'b1;
        waddr[n]      = bus_io.wr_req_addr[idx];
        wdata[n]      = bus_io.wr_req_data[idx];
        last          = idx;
        n++;
      end
      idx = wrap_inc(idx);
    end
    wr_ptr_d = (n != 0) ? wrap_inc(last) : wr_ptr_q;
  end

  // Route each port's combinational read data to the requester that owns that port.
  always_comb begin
    rd_rsp_valid_d = rd_grant;
    rd_rsp_data_d  = rd_rsp_data_q;
    for (int p = 0; p < int'(PORTS); p++) begin
      if (re[p]) begin
        rd_rsp_data_d[rd_sel[p]] = bus_io.mem_rdata[p];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      rd_rsp_valid_q <= '0;
      rd_rsp_data_q  <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rd_rsp_data_q  <= rd_rsp_data_d;
    end
  end

  assign bus_io.rd_req_ready = rd_grant;
  assign bus_io.wr_req_ready = wr_grant;
  assign bus_io.rd_rsp_valid = rd_rsp_valid_q;
  assign bus_io.rd_rsp_data  = rd_rsp_data_q;
  assign bus_io.mem_re       = re;
  assign bus_io.mem_raddr    = raddr;
  assign bus_io.mem_we       = we;
  assign bus_io.mem_waddr    = waddr;
  assign bus_io.mem_wdata    = wdata;

  a_rd_ready_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (rd_grant & ~bus_io.rd_req_valid) == '0);
  a_wr_ready_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (wr_grant & ~bus_io.wr_req_valid) == '0);
  a_rd_grant_count: assert property (@(posedge clk_i) disable iff (rst_i)
    $countones(rd_grant) == $countones(re));
  a_wr_grant_count: assert property (@(posedge clk_i) disable iff (rst_i)
    $countones(wr_grant) == $countones(we));

  for (genvar a = 0; a < int'(PORTS); a++) begin : g_wchk_a
    for (genvar b = a + 1; b < int'(PORTS); b++) begin : g_wchk_b
      a_no_dup_waddr: assert property (@(posedge clk_i) disable iff (rst_i)
        !(we[a] && we[b] && (waddr[a] == waddr[b])));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a queue-based round-robin model is checked every cycle,
// and hand-computed expectations pin the model on the key scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PORTS = 2;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .NREQ(NREQ)) b ();

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .NREQ(NREQ)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mem_init(int a);
    return (a == 5) ? WIDTH'(32'hA5) : '0;
  endfunction

  // memDP stand-in: combinational read, write at clock edge (old data on same-cycle read).
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    for (int p = 0; p < int'(PORTS); p++) begin
      b.mem_rdata[p] = mem[b.mem_raddr[p]];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < int'(DEPTH); a++) mem[a] <= mem_init(a);
    end else begin
      for (int p = 0; p < int'(PORTS); p++) begin
        if (b.mem_we[p]) mem[b.mem_waddr[p]] <= b.mem_wdata[p];
      end
    end
  end

  // Model state (m_*) and the state it moves to after the coming edge (p_*).
  int               m_rd_ptr, m_wr_ptr, p_rd_ptr, p_wr_ptr;
  logic [NREQ-1:0]  m_rsp_valid, p_rsp_valid;
  logic [WIDTH-1:0] m_rsp_data [NREQ];
  logic [WIDTH-1:0] p_rsp_data [NREQ];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               p_wa [$];
  logic [WIDTH-1:0] p_wd [$];

  always @(negedge clk) begin
    logic [NREQ-1:0]             e_rd_ready, e_wr_ready;
    logic [PORTS-1:0]            e_re, e_we;
    logic [PORTS-1:0][AW-1:0]    e_raddr, e_waddr;
    logic [PORTS-1:0][WIDTH-1:0] e_wdata;
    logic [NREQ-1:0][WIDTH-1:0]  e_rsp_data;
    int                          rq [$];
    int                          wq [$];
    logic                        dup;
    int                          r;
    rq.delete();
    wq.delete();
    e_rd_ready = '0; e_wr_ready = '0; e_re = '0; e_we = '0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0;
    if (rst) begin
      m_rd_ptr = 0; m_wr_ptr = 0; m_rsp_valid = '0;
      for (int k = 0; k < int'(NREQ); k++) m_rsp_data[k] = '0;
      for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = mem_init(a);
      p_rd_ptr = 0; p_wr_ptr = 0; p_rsp_valid = '0;
      for (int k = 0; k < int'(NREQ); k++) p_rsp_data[k] = '0;
      p_wa.delete(); p_wd.delete();
    end else begin
      m_rd_ptr = p_rd_ptr; m_wr_ptr = p_wr_ptr; m_rsp_valid = p_rsp_valid;
      for (int k = 0; k < int'(NREQ); k++) m_rsp_data[k] = p_rsp_data[k];
      for (int k = 0; k < p_wa.size(); k++) ref_mem[p_wa[k]] = p_wd[k];
      p_wa.delete(); p_wd.delete();
      for (int i = 0; i < int'(NREQ); i++) begin
        r = (m_rd_ptr + i) % NREQ;
        if (b.rd_req_valid[r] && rq.size() < int'(PORTS)) rq.push_back(r);
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        r = (m_wr_ptr + i) % NREQ;
        dup = 1'b0;
        foreach (wq[k]) if (b.wr_req_addr[wq[k]] == b.wr_req_addr[r]) dup = 1'b1;
        if (b.wr_req_valid[r] && !dup && wq.size() < int'(PORTS)) wq.push_back(r);
      end
      foreach (rq[k]) begin
        e_rd_ready[rq[k]] = 1'b1; e_re[k] = 1'b1; e_raddr[k] = b.rd_req_addr[rq[k]];
      end
      foreach (wq[k]) begin
        e_wr_ready[wq[k]] = 1'b1; e_we[k] = 1'b1;
        e_waddr[k] = b.wr_req_addr[wq[k]]; e_wdata[k] = b.wr_req_data[wq[k]];
      end
      p_rd_ptr = (rq.size() > 0) ? (rq[rq.size()-1] + 1) % NREQ : m_rd_ptr;
      p_wr_ptr = (wq.size() > 0) ? (wq[wq.size()-1] + 1) % NREQ : m_wr_ptr;
      p_rsp_valid = e_rd_ready;
      for (int k = 0; k < int'(NREQ); k++) p_rsp_data[k] = m_rsp_data[k];
      foreach (rq[k]) p_rsp_data[rq[k]] = ref_mem[b.rd_req_addr[rq[k]]];
      foreach (wq[k]) begin
        p_wa.push_back(int'(b.wr_req_addr[wq[k]]));
        p_wd.push_back(b.wr_req_data[wq[k]]);
      end
    end
    for (int k = 0; k < int'(NREQ); k++) e_rsp_data[k] = m_rsp_data[k];
    chk("cyc_rd_ready", 256'(b.rd_req_ready), 256'(e_rd_ready));
    chk("cyc_wr_ready", 256'(b.wr_req_ready), 256'(e_wr_ready));
    chk("cyc_mem_re", 256'(b.mem_re), 256'(e_re));
    chk("cyc_mem_raddr", 256'(b.mem_raddr), 256'(e_raddr));
    chk("cyc_mem_we", 256'(b.mem_we), 256'(e_we));
    chk("cyc_mem_waddr", 256'(b.mem_waddr), 256'(e_waddr));
    chk("cyc_mem_wdata", 256'(b.mem_wdata), 256'(e_wdata));
    chk("cyc_rsp_valid", 256'(b.rd_rsp_valid), 256'(m_rsp_valid));
    chk("cyc_rsp_data", 256'(b.rd_rsp_data), 256'(e_rsp_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          wait_cnt [NREQ];
    int          max_wait;
    logic [NREQ-1:0] exp_rdy;
    b.rd_req_valid = '0; b.rd_req_addr = '0;
    b.wr_req_valid = '0; b.wr_req_addr = '0; b.wr_req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 256'(b.rd_rsp_valid), 256'(0));
    step();
    rst = 1'b0;

    // 1: lone read of preloaded addr 5 by req1
    b.rd_req_valid = 4'b0010;
    b.rd_req_addr[1] = 5'd5;
    @(negedge clk);
    chk("t1_ready", 256'(b.rd_req_ready), 256'(4'b0010));
    chk("t1_re", 256'(b.mem_re), 256'(2'b01));
    chk("t1_raddr0", 256'(b.mem_raddr[0]), 256'(5'd5));
    step();
    b.rd_req_valid = '0;
    @(negedge clk);
    chk("t1_rsp_valid", 256'(b.rd_rsp_valid), 256'(4'b0010));
    chk("t1_rsp_data", 256'(b.rd_rsp_data[1]), 256'(32'hA5));
    step();
    b.rd_req_valid = 4'b1110;
    @(negedge clk);
    chk("t1_ptr_is_2", 256'(b.rd_req_ready), 256'(4'b1100));

    // 2: all four reads valid from reset
    step();
    rst = 1'b1;
    b.rd_req_valid = 4'b1111;
    b.rd_req_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    step();
    rst = 1'b0;
    max_wait = 0;
    for (int k = 0; k < int'(NREQ); k++) wait_cnt[k] = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      chk("t2_grant", 256'(b.rd_req_ready), 256'(exp_rdy));
      for (int k = 0; k < int'(NREQ); k++) begin
        wait_cnt[k] = b.rd_req_ready[k] ? 0 : wait_cnt[k] + 1;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
      step();
    end
    chk("t2_max_wait", 256'(max_wait), 256'(1));

    // 3: reqs 0 and 2 collide on addr 7
    b.rd_req_valid = '0;
    b.wr_req_valid = 4'b0101;
    b.wr_req_addr[0] = 5'd7; b.wr_req_data[0] = 32'h11;
    b.wr_req_addr[2] = 5'd7; b.wr_req_data[2] = 32'h22;
    @(negedge clk);
    chk("t3_ready_a", 256'(b.wr_req_ready), 256'(4'b0001));
    chk("t3_we_a", 256'(b.mem_we), 256'(2'b01));
    chk("t3_wdata_a", 256'(b.mem_wdata[0]), 256'(32'h11));
    step();
    b.wr_req_valid = 4'b0100;
    @(negedge clk);
    chk("t3_mem7_a", 256'(mem[7]), 256'(32'h11));
    chk("t3_ready_b", 256'(b.wr_req_ready), 256'(4'b0100));
    chk("t3_waddr_b", 256'(b.mem_waddr[0]), 256'(5'd7));
    step();
    b.wr_req_valid = '0;
    @(negedge clk);
    chk("t3_mem7_b", 256'(mem[7]), 256'(32'h22));

    // 4: same-cycle write/read of addr 3 returns old data
    step();
    b.wr_req_valid = 4'b0001; b.wr_req_addr[0] = 5'd3; b.wr_req_data[0] = 32'hFF;
    b.rd_req_valid = 4'b0010; b.rd_req_addr[1] = 5'd3;
    @(negedge clk);
    chk("t4_wr_ready", 256'(b.wr_req_ready), 256'(4'b0001));
    chk("t4_rd_ready", 256'(b.rd_req_ready), 256'(4'b0010));
    step();
    b.wr_req_valid = '0;
    @(negedge clk);
    chk("t4_old_data", 256'(b.rd_rsp_data[1]), 256'(32'h0));
    step();
    b.rd_req_valid = '0;
    @(negedge clk);
    chk("t4_new_data", 256'(b.rd_rsp_data[1]), 256'(32'hFF));

    // 5: reset in the middle of traffic
    step();
    b.rd_req_valid = 4'b1111;
    b.wr_req_valid = 4'b0010; b.wr_req_addr[1] = 5'd10; b.wr_req_data[1] = 32'h55;
    step();
    chk("t5_pre_rsp", 256'($countones(b.rd_rsp_valid)), 256'(2));
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", 256'(b.rd_rsp_valid), 256'(0));
    chk("t5_rd_ready", 256'(b.rd_req_ready), 256'(0));
    chk("t5_wr_ready", 256'(b.wr_req_ready), 256'(0));
    chk("t5_mem_re", 256'(b.mem_re), 256'(0));
    chk("t5_mem_we", 256'(b.mem_we), 256'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_grant", 256'(b.rd_req_ready), 256'(4'b0011));
    chk("t5_first_wr", 256'(b.wr_req_ready), 256'(4'b0010));

    // 6: wrap-around from rd_ptr=3
    step();
    b.wr_req_valid = '0;
    b.rd_req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_setup", 256'(b.rd_req_ready), 256'(4'b0100));
    step();
    b.rd_req_valid = 4'b1001;
    b.rd_req_addr[3] = 5'd9; b.rd_req_addr[0] = 5'd4;
    @(negedge clk);
    chk("t6_ready", 256'(b.rd_req_ready), 256'(4'b1001));
    chk("t6_re", 256'(b.mem_re), 256'(2'b11));
    chk("t6_raddr", 256'(b.mem_raddr), 256'({5'd4, 5'd9}));
    step();
    b.rd_req_valid = 4'b1111;
    @(negedge clk);
    chk("t6_ptr_is_1", 256'(b.rd_req_ready), 256'(4'b0110));
    step();
    b.rd_req_valid = '0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
